// File: rtl/seq_div4_if.sv
// seq_div4_if: start/busy/done handshake and operand/result bus of the
// 4-bit sequential divider.
//   start     : operation request, honoured only while busy is low
//   dividend  : unsigned dividend, sampled on the accepting edge
//   divisor   : unsigned divisor, sampled on the accepting edge
//   quotient  : registered quotient, held until the next completion
//   remainder : registered remainder, held until the next completion
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   dbz       : divide-by-zero flag of the last completed operation
// master drives requests (bench / client), slave is the divider.
interface seq_div4_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz
    );
endinterface

// File: rtl/seq_div4.sv
// seq_div4: 4-bit unsigned restoring divider, one trial subtraction per
// clock. Four iterations after accept, or a single cycle for a zero divisor.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, dominant over everything else
//   bus : seq_div4_if.slave (start/operands in, results/busy/done/dbz out)
module seq_div4 (
    input  logic         clk,
    input  logic         rst,
    seq_div4_if.slave    bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    logic [0:0] state_r;
    logic [1:0] cnt_r;
    logic [4:0] p_r;        // partial remainder
    logic [3:0] q_r;        // dividend shifting out / quotient shifting in
    logic [3:0] dvs_r;      // captured divisor
    logic [3:0] quotient_r;
    logic [3:0] remainder_r;
    logic       busy_r;
    logic       done_r;
    logic       dbz_r;

    logic [4:0] p_shift_s;
    logic [4:0] t_s;
    logic [4:0] p_next_s;
    logic [3:0] q_next_s;

    // 5-bit trial subtract done as an add of the inverted divisor plus one;
    // bit 4 set means the shifted remainder was smaller than the divisor.
    function automatic logic [4:0] trial_sub(input logic [4:0] a, input logic [3:0] d);
        trial_sub = a + {1'b1, ~d} + 5'd1;
    endfunction

    // One restoring-division step from the current P/Q registers.
    always_comb begin
        p_shift_s = {p_r[3:0], q_r[3]};
        t_s       = trial_sub(p_shift_s, dvs_r);
        p_next_s  = p_shift_s;
        q_next_s  = {q_r[2:0], 1'b0};
        if (t_s[4] == 1'b0) begin
            p_next_s = t_s;
            q_next_s = {q_r[2:0], 1'b1};
        end else begin
            p_next_s = p_shift_s;
            q_next_s = {q_r[2:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            p_r         <= 5'd0;
            q_r         <= 4'd0;
            dvs_r       <= 4'd0;
            quotient_r  <= 4'd0;
            remainder_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvs_r   <= bus.divisor;
                        q_r     <= bus.dividend;
                        p_r     <= 5'd0;
                        cnt_r   <= 2'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (dvs_r == 4'd0) begin
                        // Q still holds the untouched dividend here.
                        quotient_r  <= 4'hF;
                        remainder_r <= q_r;
                        dbz_r       <= 1'b1;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        p_r <= p_next_s;
                        q_r <= q_next_s;
                        if (cnt_r == 2'd3) begin
                            quotient_r  <= q_next_s;
                            remainder_r <= p_next_s[3:0];
                            dbz_r       <= 1'b0;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            cnt_r  <= cnt_r + 2'd1;
                            done_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dbz       = dbz_r;
endmodule

// File: tb/tb_seq_div4.sv
// tb_seq_div4: scoreboard bench for seq_div4. The driver pushes the expected
// result and completion cycle for every accepted start; an independent
// monitor pops and compares on each done pulse and checks that results hold
// between completions.
module tb_seq_div4;
    typedef struct packed {
        logic [8:0] res;   // {quotient, remainder, dbz}
        int         cyc;   // cycle count at which done must be visible
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_cmp;
    int          n_err;
    int          n_done;
    int          n_push;
    logic        seen_rst;
    logic [8:0]  hold_exp;
    exp_t        exp_q[$];

    seq_div4_if bus();

    seq_div4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pop on done, hold check otherwise.
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] got;
        got = {bus.quotient, bus.remainder, bus.dbz};
        if (rst) begin
            seen_rst = 1'b1;
            hold_exp = 9'd0;
        end else if (seen_rst) begin
            if (bus.done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (bus.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_with_busy: busy=%b required 0", bus.busy);
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done at cycle %0d: got q=%0d r=%0d dbz=%b, no result expected",
                             cyc, bus.quotient, bus.remainder, bus.dbz);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (got !== e.res) begin
                        n_err++;
                        $display("FAIL result: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                                 got[8:5], got[4:1], got[0], e.res[8:5], e.res[4:1], e.res[0]);
                    end
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
                    end
                    hold_exp = e.res;
                end
            end else begin
                n_cmp++;
                if (got !== hold_exp || bus.done !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold at cycle %0d: got q=%0d r=%0d dbz=%b done=%b, required q=%0d r=%0d dbz=%b done=0",
                             cyc, got[8:5], got[4:1], got[0], bus.done, hold_exp[8:5], hold_exp[4:1], hold_exp[0]);
                end
            end
        end
    end

    // Issue one operation; waits (bounded) for busy low, holds start across
    // exactly one rising edge, optionally registers the expected result.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic push,
                         input logic [3:0] eq, input logic [3:0] er, input logic ed);
        int   w;
        exp_t e;
        @(negedge clk);
        w = 0;
        while (bus.busy !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy_timeout: busy=%b required 0 within 40 cycles", bus.busy);
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) begin
            e.res = {eq, er, ed};
            e.cyc = cyc + 1 + ((b == 4'd0) ? 1 : 4);
            exp_q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int w;
        cyc = 0; n_cmp = 0; n_err = 0; n_done = 0; n_push = 0;
        seen_rst = 1'b0;
        hold_exp = 9'd0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        n_cmp++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz);
        end

        // Directed vectors with hand-computed results
        issue(4'd13, 4'd3,  1'b1, 4'd4,  4'd1, 1'b0);
        n_cmp++;
        @(negedge clk);
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: busy=%b required 1", bus.busy);
        end
        issue(4'd15, 4'd1,  1'b1, 4'd15, 4'd0, 1'b0);
        issue(4'd7,  4'd9,  1'b1, 4'd0,  4'd7, 1'b0);
        issue(4'd15, 4'd15, 1'b1, 4'd1,  4'd0, 1'b0);
        issue(4'd9,  4'd0,  1'b1, 4'hF,  4'd9, 1'b1);
        issue(4'd8,  4'd2,  1'b1, 4'd4,  4'd0, 1'b0);

        // Start during busy must be ignored
        issue(4'd14, 4'd4,  1'b1, 4'd3,  4'd2, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 4'd3; bus.divisor = 4'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Reset aborts an in-flight operation
        issue(4'd11, 4'd2,  1'b0, 4'd0,  4'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz} !== 11'd0) begin
            n_err++;
            $display("FAIL abort_state: q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.dbz);
        end
        repeat (6) @(negedge clk);
        issue(4'd6,  4'd5,  1'b1, 4'd1,  4'd1, 1'b0);

        // Back-to-back: second start lands in the first done cycle
        issue(4'd10, 4'd3,  1'b1, 4'd3,  4'd1, 1'b0);
        issue(4'd12, 4'd5,  1'b1, 4'd2,  4'd2, 1'b0);

        // Exhaustive sweep against a reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    issue(4'(a), 4'(b), 1'b1, 4'hF, 4'(a), 1'b1);
                else
                    issue(4'(a), 4'(b), 1'b1, 4'(a / b), 4'(a % b), 1'b0);
            end
        end

        // Drain the scoreboard (bounded)
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        n_cmp++;
        if (n_done != n_push) begin
            n_err++;
            $display("FAIL done_count: got %0d done pulses, required %0d", n_done, n_push);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
